// File: rtl/kf_seq_if.sv
// kf_seq_if: sequencer <-> kf_core control bundle plus the measurement stream.
//   master : sequencer side. Drives the Router A/B and AU controls and ext_ready.
//            Receives ext_data/ext_valid, au_done and au_busy.
//   slave  : core/source side. The same signals with the directions reversed.
interface kf_seq_if #(
  parameter int W     = 24,
  parameter int ADDRW = 6
);
  // measurement stream
  logic [W-1:0]     ext_data;
  logic             ext_valid;
  logic             ext_ready;
  // Router A
  logic [W-1:0]     DATA_IN;
  logic [ADDRW-1:0] CTL_A, CTL_B, DB_WADDR;
  logic             DIR_EXT, WRITE_REQ, READY_G, sel_dira, sel_dirb;
  logic [1:0]       sel_data, sel_write;
  // Router B
  logic [1:0]       sel_R, sel_S, sel_I;
  logic             inv_R, inv_S;
  // AU
  logic             au_start, au_done, au_busy;
  logic [1:0]       op_sel, mul_y_sel;

  modport master (
    input  ext_data, ext_valid, au_done, au_busy,
    output ext_ready, DATA_IN, CTL_A, CTL_B, DB_WADDR, DIR_EXT, WRITE_REQ, READY_G,
           sel_dira, sel_dirb, sel_data, sel_write, sel_R, sel_S, sel_I, inv_R, inv_S,
           au_start, op_sel, mul_y_sel
  );
  modport slave (
    output ext_data, ext_valid, au_done, au_busy,
    input  ext_ready, DATA_IN, CTL_A, CTL_B, DB_WADDR, DIR_EXT, WRITE_REQ, READY_G,
           sel_dira, sel_dirb, sel_data, sel_write, sel_R, sel_S, sel_I, inv_R, inv_S,
           au_start, op_sel, mul_y_sel
  );
endinterface

// File: rtl/kf_seq.sv
// kf_seq: microcode sequencer for kf_core.
// Runs a program from an internal instruction RAM (word = {op, dst, srcA, srcB}),
// issues AU operations, waits for au_done, writes results back to the Data Bank
// and streams measurement words into the Data Bank via ext_valid/ext_ready.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                run pulse (accepted in IDLE only), program starts at PC 0
//   busy / done / err    running / one-cycle end pulse / sticky error
//   pc                   current program counter
//   prog_we/addr/wdata   instruction RAM write port (ignored while running)
//   bus                  kf_seq_if.master: core controls, AU handshake, ext stream
// All control outputs are decoded from registered state, so reset forces them
// to 0 immediately.
module kf_seq #(
  parameter int W      = 24,
  parameter int ADDRW  = 6,
  parameter int PDEPTH = 64,
  parameter int PAW    = 6,
  parameter int TMO    = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [PAW-1:0] pc,
  input  logic           prog_we,
  input  logic [PAW-1:0] prog_addr,
  input  logic [21:0]    prog_wdata,
  kf_seq_if.master       bus
);
  localparam int CW = $clog2(TMO + 1);
  localparam logic [3:0] OP_NOP = 4'd0, OP_SUB = 4'd2, OP_MUL = 4'd3, OP_DIV = 4'd4,
                         OP_MOV = 4'd5, OP_LOAD = 4'd6, OP_HALT = 4'd7;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WB, S_LDW, S_FIN} state_t;

  state_t          state, state_n;
  logic [21:0]     ram [PDEPTH];
  logic [21:0]     ir, ir_n, fetch;
  logic [PAW-1:0]  pc_n;
  logic            err_n, go_next, last, hold;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      op;

  assign fetch = ram[pc];
  assign op    = ir[21:18];
  assign last  = (pc == PAW'(PDEPTH - 1));
  // operand/op controls stay put from ISSUE until the write-back completes
  assign hold  = (state == S_ISSUE) || (state == S_WAIT) || (state == S_WB);

  // program RAM: no reset, writes only while idle
  always_ff @(posedge clk)
    if (prog_we && state == S_IDLE) ram[prog_addr] <= prog_wdata;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ir    <= ir_n;
      err   <= err_n;
      cnt   <= cnt_n;
    end
  end

  // next state
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    err_n   = err;
    cnt_n   = cnt;
    go_next = 1'b0;
    unique case (state)
      S_IDLE:
        if (start) begin
          state_n = S_FETCH;
          pc_n    = '0;
          err_n   = 1'b0;
        end
      S_FETCH: begin
        ir_n = fetch;
        case (fetch[21:18])
          OP_NOP:  go_next = 1'b1;
          OP_HALT: state_n = S_FIN;
          OP_LOAD: state_n = S_LDW;
          default:
            if (fetch[21:18] > OP_HALT) begin
              err_n   = 1'b1;
              state_n = S_FIN;
            end else begin
              state_n = S_ISSUE;
            end
        endcase
      end
      S_ISSUE: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT:
        // au_done wins over a timeout landing on the same cycle
        if (bus.au_done) begin
          state_n = S_WB;
        end else if (cnt == CW'(TMO - 1)) begin
          err_n   = 1'b1;
          state_n = S_FIN;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      S_WB:  go_next = 1'b1;
      S_LDW: go_next = bus.ext_valid;
      S_FIN: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // the last RAM slot has no successor: finish with error instead of wrapping
    if (go_next) begin
      if (last) begin
        err_n   = 1'b1;
        state_n = S_FIN;
      end else begin
        pc_n    = pc + 1'b1;
        state_n = S_FETCH;
      end
    end
  end

  // outputs
  always_comb begin
    busy          = (state != S_IDLE) && (state != S_FIN);
    done          = (state == S_FIN);
    bus.ext_ready = (state == S_LDW);
    bus.WRITE_REQ = (state == S_WB) || (state == S_LDW && bus.ext_valid);
    bus.sel_data  = (state == S_WB) ? 2'b01 : 2'b00;
    bus.DB_WADDR  = (state == S_WB || state == S_LDW) ? ADDRW'(ir[17:12]) : '0;
    bus.au_start  = (state == S_ISSUE);
    bus.CTL_A     = hold ? ADDRW'(ir[11:6]) : '0;
    bus.CTL_B     = hold ? ADDRW'(ir[5:0])  : '0;
    bus.op_sel    = 2'b00;
    bus.mul_y_sel = 2'b00;
    bus.sel_S     = 2'b00;
    if (hold) begin
      case (op)
        OP_SUB:  bus.op_sel = 2'b01;
        OP_MUL:  bus.op_sel = 2'b10;
        OP_DIV:  begin bus.op_sel = 2'b11; bus.mul_y_sel = 2'b10; end
        OP_MOV:  bus.sel_S = 2'b10;   // S operand zeroed: dst = srcA through the adder
        default: bus.op_sel = 2'b00;
      endcase
    end
  end

  assign bus.DATA_IN   = W'(bus.ext_data);
  assign bus.DIR_EXT   = 1'b0;
  assign bus.sel_dira  = 1'b0;
  assign bus.sel_dirb  = 1'b0;
  assign bus.sel_write = 2'b00;
  assign bus.READY_G   = 1'b0;
  assign bus.inv_R     = 1'b0;
  assign bus.inv_S     = 1'b0;
  assign bus.sel_I     = 2'b00;
  assign bus.sel_R     = 2'b00;

  // au_busy is informational only
  logic unused_au_busy;
  assign unused_au_busy = bus.au_busy;
endmodule

// File: tb/tb_kf_seq.sv
// tb_kf_seq: directed bench for kf_seq. A core model (Data Bank, AU, ext source)
// runs on the falling clock; expected writes, issues and done events are queued
// by the stimulus and popped by the monitor when the DUT presents them.
module tb_kf_seq;
  localparam int W = 24, ADDRW = 6, PAW = 6, TMO = 255;
  localparam logic [21:0] LD1 = 22'h181000, LD2 = 22'h182000, ADD3 = 22'h043042,
                          DIV4 = 22'h104042, HALT = 22'h1C0000, ILL = 22'h240000;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, prog_we = 1'b0;
  logic [PAW-1:0] prog_addr = '0;
  logic [21:0]    prog_wdata = '0;
  logic busy, done, err;
  logic [PAW-1:0] pc;

  kf_seq_if #(.W(W), .ADDRW(ADDRW)) bus ();
  kf_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
              .pc(pc), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
              .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed { logic [5:0] a; logic [23:0] d; } wr_t;
  typedef struct packed { logic [5:0] a, b; logic [1:0] op, my, ss; } iss_t;
  typedef struct packed { logic e; logic [5:0] pc; } dn_t;
  wr_t  wr_q[$];
  iss_t iss_q[$];
  dn_t  dn_q[$];
  logic [23:0] ext_q[$];

  int n_chk = 0, n_pass = 0;
  int au_lat = 2, stall_cfg = 0, stall_left = 0, stall_cyc = 0, stall_wr = 0;
  int done_cnt = 0, au_seen = 0, cyc = 0, done_cyc = 0, au_start_cyc = 0;
  logic done_in_issue = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return 64'({busy, done, err, pc, bus.ext_ready, bus.WRITE_REQ, bus.au_start, bus.CTL_A,
                bus.CTL_B, bus.DB_WADDR, bus.sel_data, bus.op_sel, bus.mul_y_sel, bus.sel_S,
                bus.DIR_EXT, bus.sel_dira, bus.sel_dirb, bus.sel_write, bus.READY_G,
                bus.inv_R, bus.inv_S, bus.sel_I, bus.sel_R});
  endfunction

  // core model + monitor
  initial begin
    logic [23:0] db [64];
    logic [23:0] au_res, ra, rb, val;
    logic [11:0] ctl0;
    logic prev_xfer, au_pend, au_act, ctl_chg;
    int au_left;
    wr_t w; iss_t s; dn_t d;
    for (int i = 0; i < 64; i++) db[i] = '0;
    prev_xfer = 0; au_pend = 0; au_act = 0; ctl_chg = 0; au_left = 0; au_res = '0; ctl0 = '0;
    bus.ext_data = '0; bus.ext_valid = 1'b0; bus.au_done = 1'b0; bus.au_busy = 1'b0;
    forever begin
      @(negedge clk);
      // drive phase
      bus.au_done = 1'b0;
      if (prev_xfer) begin
        void'(ext_q.pop_front());
        stall_left = stall_cfg;
      end
      if (au_pend) begin
        if (au_left == 0) begin bus.au_done = 1'b1; au_pend = 0; end
        else au_left--;
      end
      bus.ext_valid = (ext_q.size() > 0) && (stall_left == 0);
      bus.ext_data  = (ext_q.size() > 0) ? ext_q[0] : '0;
      if (!bus.ext_valid && bus.ext_ready && stall_left > 0) stall_left--;
      bus.au_busy = au_pend;
      #1;
      // monitor phase
      cyc++;
      if (!rst_n) begin
        prev_xfer = 0; au_pend = 0; au_act = 0;
        continue;
      end
      prev_xfer = bus.ext_ready && bus.ext_valid;
      if (bus.ext_ready && !bus.ext_valid) begin
        stall_cyc++;
        if (bus.WRITE_REQ) stall_wr++;
      end
      if (bus.au_start) begin
        au_seen++;
        au_start_cyc = cyc;
        if (iss_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_issue: ctl_a %0d ctl_b %0d", bus.CTL_A, bus.CTL_B);
        end else begin
          s = iss_q.pop_front();
          chk("issue", 64'({bus.CTL_A, bus.CTL_B, bus.op_sel, bus.mul_y_sel, bus.sel_S}), 64'(s));
        end
        ra = db[bus.CTL_A];
        rb = db[bus.CTL_B];
        case (bus.op_sel)
          2'b00:   au_res = (bus.sel_S == 2'b10) ? ra : ra + rb;
          2'b01:   au_res = ra - rb;
          2'b10:   au_res = 24'((48'(ra) * 48'(rb)) >> 14);
          default: au_res = 24'((48'(ra) << 14) / 48'(rb));
        endcase
        au_pend = (au_lat > 0);
        au_left = au_lat - 1;
        if (done_in_issue) bus.au_done = 1'b1;  // must be ignored by the DUT
        ctl0 = {bus.CTL_A, bus.CTL_B};
        au_act = 1; ctl_chg = 0;
      end else if (au_act && {bus.CTL_A, bus.CTL_B} != ctl0) begin
        ctl_chg = 1;
      end
      if (bus.WRITE_REQ) begin
        if (bus.sel_data == 2'b01) begin
          chk("ctl_hold", 64'(ctl_chg), 64'(0));
          au_act = 0;
          val = au_res;
        end else if (bus.sel_data == 2'b00) val = bus.DATA_IN;
        else val = 'x;
        if (wr_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: addr %0d data %h", bus.DB_WADDR, val);
        end else begin
          w = wr_q.pop_front();
          chk("write", 64'({bus.DB_WADDR, val}), 64'(w));
        end
        db[bus.DB_WADDR] = val;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (dn_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: err %0b pc %0d", err, pc);
        end else begin
          d = dn_q.pop_front();
          chk("done_err", 64'(err), 64'(d.e));
          chk("done_pc", 64'(pc), 64'(d.pc));
          chk("done_busy", 64'(busy), 64'(0));
        end
      end
    end
  end

  task automatic prog(input logic [5:0] a, input logic [21:0] dat);
    @(negedge clk); prog_we = 1'b1; prog_addr = a; prog_wdata = dat;
    @(negedge clk); prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic kick(input string nm);
    pulse_start();
    chk({nm, "_err_clr"}, 64'(err), 64'(0));
    chk({nm, "_busy"}, 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin @(negedge clk); n++; end
    chk({nm, "_done_seen"}, 64'(done_cnt != d0), 64'(1));
    @(negedge clk);
    chk({nm, "_wr_drain"}, 64'(wr_q.size()), 64'(0));
  endtask

  task automatic wait_issue(input string nm, input int budget);
    int a0, n;
    a0 = au_seen; n = 0;
    while (au_seen == a0 && n < budget) begin @(negedge clk); n++; end
    chk({nm, "_issue_seen"}, 64'(au_seen != a0), 64'(1));
  endtask

  // two LOADs of 1.0 and 2.0, then the op at PC 2 writing rd
  task automatic expect_loads();
    ext_q.push_back(24'h004000);
    ext_q.push_back(24'h008000);
    wr_q.push_back('{a: 6'd1, d: 24'h004000});
    wr_q.push_back('{a: 6'd2, d: 24'h008000});
  endtask

  task automatic expect_add();
    expect_loads();
    wr_q.push_back('{a: 6'd3, d: 24'h00C000});
    iss_q.push_back('{a: 6'd1, b: 6'd2, op: 2'b00, my: 2'b00, ss: 2'b00});
    dn_q.push_back('{e: 1'b0, pc: 6'd3});
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", outs(), 64'(0));

    prog(6'd0, LD1); prog(6'd1, LD2); prog(6'd2, ADD3); prog(6'd3, HALT);

    // LOAD/LOAD/ADD/HALT, ext_valid always high
    au_lat = 2;
    expect_add();
    kick("add");
    wait_done("add", 100);

    // same program, 5 stall cycles in front of each word
    stall_cfg = 5; stall_left = 5; stall_cyc = 0; stall_wr = 0;
    expect_add();
    kick("stall");
    wait_done("stall", 200);
    chk("stall_cycles", 64'(stall_cyc), 64'(10));
    chk("stall_no_write", 64'(stall_wr), 64'(0));
    stall_cfg = 0; stall_left = 0;

    // DIV 1.0/2.0, au_done also pulsed during ISSUE
    prog(6'd2, DIV4);
    au_lat = 3; done_in_issue = 1'b1;
    expect_loads();
    wr_q.push_back('{a: 6'd4, d: 24'h002000});
    iss_q.push_back('{a: 6'd1, b: 6'd2, op: 2'b11, my: 2'b10, ss: 2'b00});
    dn_q.push_back('{e: 1'b0, pc: 6'd3});
    kick("div");
    wait_done("div", 100);
    done_in_issue = 1'b0;

    // illegal opcode at PC 2
    prog(6'd2, ILL);
    expect_loads();
    dn_q.push_back('{e: 1'b1, pc: 6'd2});
    kick("ill");
    wait_done("ill", 100);
    chk("err_sticky", 64'(err), 64'(1));

    // AU never answers: timeout; start and prog_we while busy are ignored
    prog(6'd2, ADD3);
    au_lat = 0;
    expect_loads();
    iss_q.push_back('{a: 6'd1, b: 6'd2, op: 2'b00, my: 2'b00, ss: 2'b00});
    dn_q.push_back('{e: 1'b1, pc: 6'd2});
    kick("tmo");                      // also shows the new start cleared err
    wait_issue("tmo", 50);
    repeat (5) @(negedge clk);
    pulse_start();
    prog(6'd3, 22'h000000);
    wait_done("tmo", 400);
    chk("tmo_latency", 64'(done_cyc - au_start_cyc), 64'(TMO + 1));

    // reset in the middle of WAIT
    expect_loads();
    iss_q.push_back('{a: 6'd1, b: 6'd2, op: 2'b00, my: 2'b00, ss: 2'b00});
    kick("rst");
    wait_issue("rst", 50);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outs", outs(), 64'(0));
    @(negedge clk);
    chk("rst_held_outs", outs(), 64'(0));
    rst_n = 1'b1;
    chk("rst_wr_drain", 64'(wr_q.size()), 64'(0));

    // rerun from preserved RAM (HALT at PC 3 untouched)
    au_lat = 1;
    expect_add();
    kick("rerun");
    wait_done("rerun", 100);

    repeat (3) @(negedge clk);
    chk("issue_drain", 64'(iss_q.size()), 64'(0));
    chk("done_drain", 64'(dn_q.size()), 64'(0));
    chk("end_idle", 64'(busy), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/kf_seq.md
Name: kf_seq

Overview:
Microcode sequencer for kf_core. It runs a program held in an internal instruction RAM and drives every Router A, Router B and AU control pin of the core. It fetches each instruction, issues the AU operation, waits for au_done and writes the result back to the Data Bank. It also streams external measurement words into the Data Bank through a valid/ready handshake.

Parameters:
W, 24, datapath word width (sign-magnitude, FRAC=14 in core)
ADDRW, 6, Data Bank address width
PDEPTH, 64, instruction RAM depth
PAW, 6, program counter width (2^PAW >= PDEPTH)
TMO, 255, max cycles in WAIT before timeout error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  run pulse; program starts at PC 0
busy  out  1  high from start acceptance until FIN
done  out  1  one-cycle pulse on program end
err  out  1  sticky error; cleared by next accepted start
pc  out  PAW  current program counter
prog_we  in  1  instruction RAM write enable
prog_addr  in  PAW  instruction RAM write address
prog_wdata  in  22  instruction {op[21:18], dst[17:12], srcA[11:6], srcB[5:0]}
ext_data  in  W  measurement word
ext_valid  in  1  ext_data valid
ext_ready  out  1  ext_data consumed this cycle
DATA_IN, CTL_A, CTL_B, DIR_EXT, WRITE_REQ, READY_G, sel_data, sel_dira, sel_dirb, sel_write, DB_WADDR  out  per core  Router A controls
sel_R, sel_S, inv_R, inv_S, sel_I  out  per core  Router B controls
au_start, op_sel, mul_y_sel  out  per core  AU controls
au_done  in  1  AU completion pulse
au_busy  in  1  AU busy (observed only)

Behaviour:
- Reset (async, rst_n=0): state IDLE, pc=0, busy=done=err=ext_ready=0, every core control output 0, including au_start and WRITE_REQ. Instruction RAM contents are not reset. Reset mid-program aborts immediately, with no further write or au_start.
- Constant outputs: DIR_EXT=0, sel_dira=sel_dirb=0, sel_write=00, READY_G=0, inv_R=inv_S=0, sel_I=00, sel_R=00. DATA_IN=ext_data.
- Opcodes: 0 NOP; 1 ADD; 2 SUB; 3 MUL (mul_y_sel=00); 4 DIV (mul_y_sel=10); 5 MOV (ADD with sel_S=10, so dst=srcA); 6 LOAD (dst=ext_data); 7 HALT; 8-15 illegal.
- AU mapping: op_sel 00/01/10/11 for ADD/SUB/MUL/DIV; MOV uses 00.
- Instruction RAM: synchronous write, accepted only in IDLE (prog_we ignored while busy). Read is asynchronous, latched into ir in FETCH.
- start is accepted only in IDLE. Acceptance clears err, sets pc=0, busy=1 and moves to FETCH. start while busy is ignored.
- FETCH (1 cycle): ir<=ram[pc].
  - NOP: pc+1, FETCH.
  - HALT: FIN.
  - illegal: err=1, FIN.
  - LOAD: LDW.
  - otherwise: ISSUE.
- ISSUE (1 cycle): CTL_A=srcA, CTL_B=srcB, op_sel/mul_y_sel/sel_S driven, au_start=1, timeout counter cleared. Then WAIT.
- WAIT: CTL_A/CTL_B/op_sel/sel_S are held from ISSUE until WB ends. au_start=0.
  - au_done=1: go to WB.
  - counter reaches TMO first: err=1, FIN.
  - au_done seen during ISSUE is ignored.
- WB (1 cycle): sel_data=01, WRITE_REQ=1, DB_WADDR=dst. Then pc+1, FETCH.
- LDW: ext_ready=1 while in LDW. In the cycle with ext_valid=1: sel_data=00, WRITE_REQ=1, DB_WADDR=dst, then pc+1, FETCH. With ext_valid=0 it stays in LDW, WRITE_REQ=0, no timeout.
- WRITE_REQ is 1 only in WB or in the LDW transfer cycle; it is 0 in all other states.
- FIN (1 cycle): done=1, busy=0, then IDLE. pc holds its last value.
- PC end: if the instruction at PDEPTH-1 is not HALT/illegal, it executes normally, then err=1, FIN. pc does not wrap.
- Latency: arithmetic/MOV instruction = 3 + (WAIT cycles, >=1). LOAD = 1 + LDW cycles. NOP = 1.

Test Plan:
- Prog {LOAD r1; LOAD r2; ADD r3=r1+r2; HALT}, ext_data 0x004000 then 0x008000 (ext_valid always high) -> db[3]=0x00C000, exactly 3 WRITE_REQ pulses, one done pulse, err=0.
- Same prog with ext_valid low 5 cycles before each word -> ext_ready high throughout LDW, no WRITE_REQ during stall, same final db[3].
- DIV r4=r1/r2 (1.0/2.0) -> in ISSUE, op_sel=11 and mul_y_sel=10; db[4]=0x002000 after AU done; CTL_A/CTL_B stable from ISSUE through WB.
- Opcode 9 at PC 2 -> err=1 and done pulse after FETCH of PC 2, no write for PC 2, pc=2; next start clears err.
- au_done forced low -> err=1 after TMO WAIT cycles, no WB; start and prog_we issued while busy are ignored.
- rst_n low during WAIT -> all outputs 0 asynchronously, IDLE; program RAM preserved; rerun gives correct result.
